pipe_mem_stage_ws: RTL and testbench

Parametrised MEM pipeline stage. It contains the EX/MEM pipeline register, store-data forwarding from WB, and a byte-addressable data memory that supports byte, halfword and word accesses with sign or zero extension. Memory accesses take a configurable number of wait states. During those wait states the stage stalls the upstream pipeline and sends bubbles to WB.

---
 rtl/pipe_mem_stage_ws_if.sv | 44 ++++
 rtl/pipe_mem_stage_ws.sv | 142 ++++++++++++++
 tb/tb_pipe_mem_stage_ws.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mem_stage_ws_if.sv
// rtl/pipe_mem_stage_ws_if.sv - EX-side inputs and MEM-side outputs of the MEM pipeline stage.
// MEMmisalign exists only when MEM_MISALIGN_TRAP_EN is defined.
interface pipe_mem_stage_ws_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              EXwreg;
    logic              EXm2reg;
    logic              EXwmem;
    logic              EXisStoreHazards;
    logic [1:0]        EXsize;
    logic              EXsignExt;
    logic [REG_W-1:0]  EXwn;
    logic [DATA_W-1:0] EXaluResult;
    logic [DATA_W-1:0] EXqb;
    logic [DATA_W-1:0] WBdata;
    logic              MEMwreg;
    logic              MEMm2reg;
    logic [REG_W-1:0]  MEMwn;
    logic [DATA_W-1:0] MEMaluResult;
    logic [DATA_W-1:0] MEMmemOut;
    logic              MEMstall;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              MEMmisalign;
`endif

    modport master (
        output EXwreg, EXm2reg, EXwmem, EXisStoreHazards, EXsize, EXsignExt,
        output EXwn, EXaluResult, EXqb, WBdata,
        input  MEMwreg, MEMm2reg, MEMwn, MEMaluResult, MEMmemOut, MEMstall
`ifdef MEM_MISALIGN_TRAP_EN
        , input MEMmisalign
`endif
    );

    modport slave (
        input  EXwreg, EXm2reg, EXwmem, EXisStoreHazards, EXsize, EXsignExt,
        input  EXwn, EXaluResult, EXqb, WBdata,
        output MEMwreg, MEMm2reg, MEMwn, MEMaluResult, MEMmemOut, MEMstall
`ifdef MEM_MISALIGN_TRAP_EN
        , output MEMmisalign
`endif
    );
endinterface

// File: rtl/pipe_mem_stage_ws.sv
// rtl/pipe_mem_stage_ws.sv - MEM stage: EX/MEM register, store forwarding, byte-lane data memory, wait states.
// Optional MEM_MISALIGN_TRAP_EN: flag misaligned half/word accesses and suppress their effects.
module pipe_mem_stage_ws #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int REG_W       = 5,
    parameter int WAIT_STATES = 0
) (
    input logic                clk,
    input logic                clrn,
    pipe_mem_stage_ws_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] di_lat;

    logic              wreg_r, m2reg_r, wmem_r, haz_r, sext_r;
    logic [1:0]        size_r;
    logic [REG_W-1:0]  wn_r;
    logic [DATA_W-1:0] alu_r, qb_r;

    logic              mem_op, stall, trap;
    logic [DATA_W-1:0] di, di_st, wdata, rd_word, mem_out;
    logic [3:0]        lanes, be;
    logic [ADDR_W-1:0] waddr;
    logic [1:0]        boff;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    logic [DATA_W-1:0] mem [DEPTH];

    assign mem_op = wmem_r | m2reg_r;
    assign di     = haz_r ? bus.WBdata : qb_r;
    assign di_st  = (WAIT_STATES != 0) ? di_lat : di;
    assign waddr  = alu_r[ADDR_W+1:2];
    assign boff   = alu_r[1:0];

    // The first MEM cycle (IDLE) already counts as one stall, so WAIT runs WAIT_STATES-1 more.
    assign stall = ((state == IDLE) && mem_op && (WAIT_STATES != 0)) ||
                   ((state == WAIT) && (cnt != 4'd0));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            di_lat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && (WAIT_STATES != 0)) begin
                        state  <= WAIT;
                        cnt    <= 4'(WAIT_STATES - 1);
                        di_lat <= di;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    else             state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wreg_r  <= 1'b0;
            m2reg_r <= 1'b0;
            wmem_r  <= 1'b0;
            haz_r   <= 1'b0;
            sext_r  <= 1'b0;
            size_r  <= 2'b00;
            wn_r    <= '0;
            alu_r   <= '0;
            qb_r    <= '0;
        end else if (!stall) begin
            wreg_r  <= bus.EXwreg;
            m2reg_r <= bus.EXm2reg;
            wmem_r  <= bus.EXwmem;
            haz_r   <= bus.EXisStoreHazards;
            sext_r  <= bus.EXsignExt;
            size_r  <= bus.EXsize;
            wn_r    <= bus.EXwn;
            alu_r   <= bus.EXaluResult;
            qb_r    <= bus.EXqb;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = mem_op && (((size_r == 2'b01) && boff[0]) || (size_r[1] && (boff != 2'b00)));
    assign bus.MEMmisalign = trap & ~stall;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        lanes = 4'b1111;
        wdata = di_st;
        case (size_r)
            2'b00: begin
                lanes = 4'b0001 << boff;
                wdata = {4{di_st[7:0]}};
            end
            2'b01: begin
                lanes = boff[1] ? 4'b1100 : 4'b0011;
                wdata = {2{di_st[15:0]}};
            end
            default: ;
        endcase
    end

    assign be = (wmem_r && !stall && !trap) ? lanes : 4'b0000;

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (be[l]) mem[waddr][8*l +: 8] <= wdata[8*l +: 8];
        end
    end

    assign rd_word = mem[waddr];
    assign rd_byte = rd_word[{boff, 3'b000} +: 8];
    assign rd_half = boff[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        mem_out = rd_word;
        case (size_r)
            2'b00:   mem_out = {{24{sext_r & rd_byte[7]}}, rd_byte};
            2'b01:   mem_out = {{16{sext_r & rd_half[15]}}, rd_half};
            default: ;
        endcase
    end

    assign bus.MEMwreg      = wreg_r & ~stall & ~(trap & m2reg_r);
    assign bus.MEMm2reg     = m2reg_r & ~stall;
    assign bus.MEMwn        = wn_r;
    assign bus.MEMaluResult = alu_r;
    assign bus.MEMmemOut    = mem_out;
    assign bus.MEMstall     = stall;
endmodule

// File: tb/tb_pipe_mem_stage_ws.sv
// tb/tb_pipe_mem_stage_ws.sv - directed bench for pipe_mem_stage_ws with WAIT_STATES 0, 2 and 3.
module tb_pipe_mem_stage_ws;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  sel = 2'd3;
    logic        ex_wreg = 0, ex_m2reg = 0, ex_wmem = 0, ex_haz = 0, ex_sext = 0;
    logic [1:0]  ex_size = 2'b10;
    logic [4:0]  ex_wn = '0;
    logic [31:0] ex_alu = '0, ex_qb = '0, wbdata = '0;

    logic        cur_stall, cur_wreg, cur_m2reg;
    logic [4:0]  cur_wn;
    logic [31:0] cur_alu, cur_mout;

    int n_cmp = 0;
    int n_bad = 0;
    int st;

    pipe_mem_stage_ws_if #(.DATA_W(32), .REG_W(5)) b0 ();
    pipe_mem_stage_ws_if #(.DATA_W(32), .REG_W(5)) b2 ();
    pipe_mem_stage_ws_if #(.DATA_W(32), .REG_W(5)) b3 ();

    pipe_mem_stage_ws #(.DATA_W(32), .ADDR_W(10), .REG_W(5), .WAIT_STATES(0)) u0 (.clk(clk), .clrn(clrn), .bus(b0));
    pipe_mem_stage_ws #(.DATA_W(32), .ADDR_W(10), .REG_W(5), .WAIT_STATES(2)) u2 (.clk(clk), .clrn(clrn), .bus(b2));
    pipe_mem_stage_ws #(.DATA_W(32), .ADDR_W(10), .REG_W(5), .WAIT_STATES(3)) u3 (.clk(clk), .clrn(clrn), .bus(b3));

    // Only the selected instance sees real operations; the others see bubbles.
    assign b0.EXwreg = ex_wreg & (sel == 2'd0);
    assign b0.EXm2reg = ex_m2reg & (sel == 2'd0);
    assign b0.EXwmem = ex_wmem & (sel == 2'd0);
    assign b0.EXisStoreHazards = ex_haz;
    assign b0.EXsize = ex_size;
    assign b0.EXsignExt = ex_sext;
    assign b0.EXwn = ex_wn;
    assign b0.EXaluResult = ex_alu;
    assign b0.EXqb = ex_qb;
    assign b0.WBdata = wbdata;
    assign b2.EXwreg = ex_wreg & (sel == 2'd2);
    assign b2.EXm2reg = ex_m2reg & (sel == 2'd2);
    assign b2.EXwmem = ex_wmem & (sel == 2'd2);
    assign b2.EXisStoreHazards = ex_haz;
    assign b2.EXsize = ex_size;
    assign b2.EXsignExt = ex_sext;
    assign b2.EXwn = ex_wn;
    assign b2.EXaluResult = ex_alu;
    assign b2.EXqb = ex_qb;
    assign b2.WBdata = wbdata;
    assign b3.EXwreg = ex_wreg & (sel == 2'd3);
    assign b3.EXm2reg = ex_m2reg & (sel == 2'd3);
    assign b3.EXwmem = ex_wmem & (sel == 2'd3);
    assign b3.EXisStoreHazards = ex_haz;
    assign b3.EXsize = ex_size;
    assign b3.EXsignExt = ex_sext;
    assign b3.EXwn = ex_wn;
    assign b3.EXaluResult = ex_alu;
    assign b3.EXqb = ex_qb;
    assign b3.WBdata = wbdata;

    always_comb begin
        case (sel)
            2'd0: begin
                cur_stall = b0.MEMstall; cur_wreg = b0.MEMwreg; cur_m2reg = b0.MEMm2reg;
                cur_wn = b0.MEMwn; cur_alu = b0.MEMaluResult; cur_mout = b0.MEMmemOut;
            end
            2'd2: begin
                cur_stall = b2.MEMstall; cur_wreg = b2.MEMwreg; cur_m2reg = b2.MEMm2reg;
                cur_wn = b2.MEMwn; cur_alu = b2.MEMaluResult; cur_mout = b2.MEMmemOut;
            end
            default: begin
                cur_stall = b3.MEMstall; cur_wreg = b3.MEMwreg; cur_m2reg = b3.MEMm2reg;
                cur_wn = b3.MEMwn; cur_alu = b3.MEMaluResult; cur_mout = b3.MEMmemOut;
            end
        endcase
    end

    task automatic bubble();
        ex_wreg = 0; ex_m2reg = 0; ex_wmem = 0; ex_haz = 0;
    endtask

    task automatic issue(input bit wr, input bit m2, input bit wm, input bit hz, input logic [1:0] sz,
                         input bit sx, input logic [4:0] wn, input logic [31:0] addr, input logic [31:0] qb);
        ex_wreg = wr; ex_m2reg = m2; ex_wmem = wm; ex_haz = hz; ex_size = sz;
        ex_sext = sx; ex_wn = wn; ex_alu = addr; ex_qb = qb;
    endtask

    // Issue one op, then wait (bounded) through its stall cycles; returns in its final MEM cycle.
    task automatic do_op(input bit wr, input bit m2, input bit wm, input logic [1:0] sz, input bit sx,
                         input logic [31:0] addr, input logic [31:0] qb, output int stalls);
        @(negedge clk);
        issue(wr, m2, wm, 1'b0, sz, sx, 5'd1, addr, qb);
        @(negedge clk);
        bubble();
        stalls = 0;
        while (cur_stall === 1'b1 && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        sel = 2'd3;
        issue(1, 1, 0, 0, 2'b10, 0, 5'd7, 32'h44, 32'h1);
        repeat (3) @(negedge clk);
        n_cmp++; if (cur_wreg !== 1'b0) begin n_bad++; $display("FAIL reset_wreg got %b want 0", cur_wreg); end
        n_cmp++; if (cur_m2reg !== 1'b0) begin n_bad++; $display("FAIL reset_m2reg got %b want 0", cur_m2reg); end
        n_cmp++; if (cur_wn !== 5'd0) begin n_bad++; $display("FAIL reset_wn got %0d want 0", cur_wn); end
        n_cmp++; if (cur_alu !== 32'h0) begin n_bad++; $display("FAIL reset_alu got %h want 0", cur_alu); end
        n_cmp++; if (cur_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", cur_stall); end
        bubble();
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic test_ws0_word();
        sel = 2'd0;
        do_op(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, st);
        n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL ws0_store_stall got %0d want 0", st); end
        do_op(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, st);
        n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL ws0_load_stall got %0d want 0", st); end
        n_cmp++; if (cur_mout !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ws0_load_word got %h want deadbeef", cur_mout); end
        n_cmp++; if ({cur_wreg, cur_m2reg} !== 2'b11) begin n_bad++; $display("FAIL ws0_load_ctrl got %b want 11", {cur_wreg, cur_m2reg}); end
    endtask

    task automatic test_byte_half();
        sel = 2'd0;
        do_op(0, 0, 1, 2'b00, 0, 32'h13, 32'h00000080, st);
        do_op(1, 1, 0, 2'b00, 1, 32'h13, 32'h0, st);
        n_cmp++; if (cur_mout !== 32'hFFFFFF80) begin n_bad++; $display("FAIL byte_signed got %h want ffffff80", cur_mout); end
        do_op(1, 1, 0, 2'b00, 0, 32'h13, 32'h0, st);
        n_cmp++; if (cur_mout !== 32'h00000080) begin n_bad++; $display("FAIL byte_unsigned got %h want 00000080", cur_mout); end
        do_op(0, 0, 1, 2'b01, 0, 32'h12, 32'h00001234, st);
        do_op(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, st);
        n_cmp++; if (cur_mout !== 32'h1234BEEF) begin n_bad++; $display("FAIL half_store_word got %h want 1234beef", cur_mout); end
        do_op(1, 1, 0, 2'b01, 1, 32'h10, 32'h0, st);
        n_cmp++; if (cur_mout !== 32'hFFFFBEEF) begin n_bad++; $display("FAIL half_signed got %h want ffffbeef", cur_mout); end
        do_op(1, 1, 0, 2'b01, 0, 32'h13, 32'h0, st);
        n_cmp++; if (cur_mout !== 32'h00001234) begin n_bad++; $display("FAIL half_misaligned got %h want 00001234", cur_mout); end
        do_op(1, 1, 0, 2'b00, 1, 32'h11, 32'h0, st);
        n_cmp++; if (cur_mout !== 32'hFFFFFFBE) begin n_bad++; $display("FAIL byte_lane1 got %h want ffffffbe", cur_mout); end
        do_op(1, 1, 0, 2'b11, 1, 32'h12, 32'h0, st);
        n_cmp++; if (cur_mout !== 32'h1234BEEF) begin n_bad++; $display("FAIL size3_word got %h want 1234beef", cur_mout); end
    endtask

    task automatic test_wrap();
        sel = 2'd0;
        do_op(0, 0, 1, 2'b10, 0, 32'h1004, 32'h0BADC0DE, st);
        do_op(1, 1, 0, 2'b10, 0, 32'h0004, 32'h0, st);
        n_cmp++; if (cur_mout !== 32'h0BADC0DE) begin n_bad++; $display("FAIL wrap_load got %h want 0badc0de", cur_mout); end
    endtask

    task automatic test_wait_states();
        sel = 2'd3;
        do_op(0, 0, 1, 2'b10, 0, 32'h20, 32'hA5A55A5A, st);
        n_cmp++; if (st !== 3) begin n_bad++; $display("FAIL ws3_store_stalls got %0d want 3", st); end
        @(negedge clk);
        issue(1, 1, 0, 0, 2'b10, 0, 5'd3, 32'h20, 32'h0);
        @(negedge clk);
        issue(1, 0, 0, 0, 2'b10, 0, 5'd9, 32'h77, 32'h0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (cur_stall !== 1'b1) begin n_bad++; $display("FAIL ws3_stall_c%0d got %b want 1", i, cur_stall); end
            n_cmp++; if ({cur_wreg, cur_m2reg} !== 2'b00) begin n_bad++; $display("FAIL ws3_bubble_c%0d got %b want 00", i, {cur_wreg, cur_m2reg}); end
            n_cmp++; if (cur_wn !== 5'd3) begin n_bad++; $display("FAIL ws3_hold_c%0d got %0d want 3", i, cur_wn); end
            @(negedge clk);
        end
        n_cmp++; if (cur_stall !== 1'b0) begin n_bad++; $display("FAIL ws3_final_stall got %b want 0", cur_stall); end
        n_cmp++; if ({cur_wreg, cur_m2reg} !== 2'b11) begin n_bad++; $display("FAIL ws3_final_ctrl got %b want 11", {cur_wreg, cur_m2reg}); end
        n_cmp++; if (cur_mout !== 32'hA5A55A5A) begin n_bad++; $display("FAIL ws3_final_data got %h want a5a55a5a", cur_mout); end
        @(negedge clk);
        bubble();
        n_cmp++; if (cur_wn !== 5'd9 || cur_alu !== 32'h77) begin n_bad++; $display("FAIL ws3_next_capture got wn %0d alu %h want wn 9 alu 77", cur_wn, cur_alu); end
        n_cmp++; if (cur_stall !== 1'b0 || cur_wreg !== 1'b1) begin n_bad++; $display("FAIL ws3_next_ctrl got stall %b wreg %b want 0 1", cur_stall, cur_wreg); end
    endtask

    task automatic test_forwarding();
        sel = 2'd2;
        @(negedge clk);
        issue(0, 0, 1, 1, 2'b10, 0, 5'd0, 32'h30, 32'h00000001);
        wbdata = 32'hCAFEF00D;
        @(negedge clk);
        bubble();
        n_cmp++; if (cur_stall !== 1'b1) begin n_bad++; $display("FAIL fwd_mem1_stall got %b want 1", cur_stall); end
        @(negedge clk);
        wbdata = 32'h55555555;
        n_cmp++; if (cur_stall !== 1'b1) begin n_bad++; $display("FAIL fwd_mem2_stall got %b want 1", cur_stall); end
        @(negedge clk);
        n_cmp++; if (cur_stall !== 1'b0) begin n_bad++; $display("FAIL fwd_final_stall got %b want 0", cur_stall); end
        do_op(1, 1, 0, 2'b10, 0, 32'h30, 32'h0, st);
        n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL fwd_load_stalls got %0d want 2", st); end
        n_cmp++; if (cur_mout !== 32'hCAFEF00D) begin n_bad++; $display("FAIL fwd_data got %h want cafef00d", cur_mout); end
    endtask

    task automatic test_reset_mid_wait();
        sel = 2'd3;
        do_op(0, 0, 1, 2'b10, 0, 32'h40, 32'h11111111, st);
        @(negedge clk);
        issue(0, 0, 1, 0, 2'b10, 0, 5'd5, 32'h40, 32'h22222222);
        @(negedge clk);
        bubble();
        @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        n_cmp++; if (cur_stall !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall got %b want 0", cur_stall); end
        n_cmp++; if (cur_wreg !== 1'b0 || cur_wn !== 5'd0 || cur_alu !== 32'h0) begin n_bad++; $display("FAIL rst_mid_regs got wreg %b wn %0d alu %h want 0 0 0", cur_wreg, cur_wn, cur_alu); end
        @(negedge clk);
        clrn = 1'b1;
        do_op(1, 1, 0, 2'b10, 0, 32'h40, 32'h0, st);
        n_cmp++; if (cur_mout !== 32'h11111111) begin n_bad++; $display("FAIL rst_mid_mem got %h want 11111111", cur_mout); end
    endtask

    initial begin
        test_reset();
        test_ws0_word();
        test_byte_half();
        test_wrap();
        test_wait_states();
        test_forwarding();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
